// File: rtl/key_event_pkg.sv
// Shared event codes and sizing helpers for the key event controller.
package key_event_pkg;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_HOLD    = 2'b11
  } ev_code_e;

  localparam int EV_CODE_W = 2;

  // ceil(log2(n)), never below 1 so single-entry fields still get a bit
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // FIFO record: {key index, event code}
  function automatic int ev_rec_width(input int nkeys);
    return clog2_min1(nkeys) + EV_CODE_W;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO; a push is accepted while full only
// when a pop happens on the same edge.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Shared-tick debounce for NKEYS keys, press/release/hold event generation,
// lowest-index arbitration into an event FIFO with valid/ready handshake.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int NKEYS      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 20,
  parameter int HOLD_TICKS = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NKEYS-1:0]              key,
  output logic [NKEYS-1:0]              key_state,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [clog2_min1(NKEYS)-1:0]  ev_key,
  output logic [1:0]                    ev_code,
  output logic                          ev_overflow,
  input  logic                          clr_overflow
);

  localparam int KEY_W  = clog2_min1(NKEYS);
  localparam int EV_W   = ev_rec_width(NKEYS);
  localparam int PS_W   = clog2_min1(TICK_DIV);
  localparam int DEB_W  = clog2_min1(DEB_TICKS);
  localparam int HOLD_W = clog2_min1(HOLD_TICKS);

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic [NKEYS-1:0]  sync_q1;
  logic [NKEYS-1:0]  sync_q2;
  logic [NKEYS-1:0]  s_pressed;
  logic [PS_W-1:0]   ps_cnt;
  logic              tick;

  logic [DEB_W-1:0]  deb_cnt   [NKEYS];
  logic [HOLD_W-1:0] hold_cnt  [NKEYS];
  logic [NKEYS-1:0]  hold_done;
  logic [1:0]        pend_code [NKEYS];
  logic [1:0]        raise_code[NKEYS];
  logic [NKEYS-1:0]  flip;
  logic [NKEYS-1:0]  hold_hit;
  logic              drop;

  logic              sel_valid;
  logic [KEY_W-1:0]  sel_idx;
  logic [1:0]        sel_code;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EV_W-1:0]   head_data;

  // Synchroniser resets to released so a key held through reset must debounce again
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
    end
  end

  assign s_pressed = ~sync_q2;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)  ps_cnt <= '0;
    else if (tick)   ps_cnt <= '0;
    else             ps_cnt <= ps_cnt + PS_W'(1);
  end

  assign tick = (ps_cnt == PS_LAST);

  always_comb begin
    flip      = '0;
    hold_hit  = '0;
    drop      = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_code  = EV_NONE;
    for (int i = 0; i < NKEYS; i++) begin
      raise_code[i] = EV_NONE;
      flip[i]       = tick && (s_pressed[i] != key_state[i]) && (deb_cnt[i] == DEB_LAST);
      hold_hit[i]   = tick && key_state[i] && !hold_done[i] && (hold_cnt[i] == HOLD_LAST);
      // a release on the same tick as the hold threshold wins
      if (flip[i])          raise_code[i] = s_pressed[i] ? EV_PRESS : EV_RELEASE;
      else if (hold_hit[i]) raise_code[i] = EV_HOLD;
      if (raise_code[i] != EV_NONE && pend_code[i] != EV_NONE) drop = 1'b1;
    end
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_code[i] != EV_NONE) begin
        sel_valid = 1'b1;
        sel_idx   = KEY_W'(i);
        sel_code  = pend_code[i];
      end
    end
  end

  assign pop  = ev_valid && ev_ready;
  assign push = sel_valid && (!fifo_full || pop);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_state <= '0;
      hold_done <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        deb_cnt[i]   <= '0;
        hold_cnt[i]  <= '0;
        pend_code[i] <= EV_NONE;
      end
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (tick) begin
          if (s_pressed[i] == key_state[i]) begin
            deb_cnt[i] <= '0;
          end else if (flip[i]) begin
            key_state[i] <= s_pressed[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end

          if (!key_state[i] || flip[i]) begin
            hold_cnt[i]  <= '0;
            hold_done[i] <= 1'b0;
          end else if (!hold_done[i]) begin
            if (hold_hit[i]) hold_done[i] <= 1'b1;
            else             hold_cnt[i]  <= hold_cnt[i] + HOLD_W'(1);
          end
        end

        if (push && sel_idx == KEY_W'(i))
          pend_code[i] <= EV_NONE;
        else if (raise_code[i] != EV_NONE && pend_code[i] == EV_NONE)
          pend_code[i] <= raise_code[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)        ev_overflow <= 1'b0;
    else if (drop)         ev_overflow <= 1'b1;
    else if (clr_overflow) ev_overflow <= 1'b0;
  end

  key_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .push_data ({sel_idx, sel_code}),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (head_data),
    .empty     (fifo_empty)
  );

  assign ev_valid          = !fifo_empty;
  assign {ev_key, ev_code} = ev_valid ? head_data : '0;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised and directed bench for key_event_ctrl against a queue-based
// reference model, plus hand-derived event sequences for key scenarios.
module tb_key_event_ctrl;
  import key_event_pkg::*;

  localparam int NKEYS      = 4;
  localparam int TICK_DIV   = 4;
  localparam int DEB_TICKS  = 3;
  localparam int HOLD_TICKS = 8;
  localparam int FIFO_DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] key;
  logic [3:0] key_state;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_key;
  logic [1:0] ev_code;
  logic       ev_overflow;
  logic       clr_overflow;

  always #5 sys_clk = ~sys_clk;

  key_event_ctrl #(
    .NKEYS      (NKEYS),
    .TICK_DIV   (TICK_DIV),
    .DEB_TICKS  (DEB_TICKS),
    .HOLD_TICKS (HOLD_TICKS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key          (key),
    .key_state    (key_state),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_key       (ev_key),
    .ev_code      (ev_code),
    .ev_overflow  (ev_overflow),
    .clr_overflow (clr_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: integer counters per key and a queue standing in for the FIFO
  int         m_pcnt;
  bit [3:0]   m_s1, m_s2, m_ks;
  int         m_dis   [4];
  int         m_held  [4];
  bit         m_fired [4];
  bit [1:0]   m_pend  [4];
  logic [3:0] m_q[$];
  bit         m_ovf;

  task automatic model_step();
    bit       tick, pop, push_ok, drop, old_ks;
    bit [3:0] s;
    bit [1:0] raise;
    bit [1:0] old_pend [4];
    int       sel;
    if (!sys_rst_n) begin
      m_pcnt = 0; m_s1 = '1; m_s2 = '1; m_ks = '0; m_ovf = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_dis[i] = 0; m_held[i] = 0; m_fired[i] = 0; m_pend[i] = 0;
      end
      return;
    end
    tick    = (m_pcnt == TICK_DIV - 1);
    s       = ~m_s2;
    pop     = (m_q.size() > 0) && ev_ready;
    push_ok = (m_q.size() < FIFO_DEPTH) || pop;
    sel     = -1;
    for (int i = 0; i < 4; i++) begin
      old_pend[i] = m_pend[i];
      if (sel < 0 && m_pend[i] != 0) sel = i;
    end
    if (pop) void'(m_q.pop_front());
    if (sel >= 0 && push_ok) begin
      m_q.push_back({2'(sel), m_pend[sel]});
      m_pend[sel] = 0;
    end
    drop = 0;
    for (int i = 0; i < 4; i++) begin
      raise  = 0;
      old_ks = m_ks[i];
      if (tick) begin
        if (s[i] == m_ks[i]) m_dis[i] = 0;
        else if (m_dis[i] == DEB_TICKS - 1) begin
          raise   = s[i] ? 2'b01 : 2'b10;
          m_ks[i] = s[i];
          m_dis[i] = 0;
        end else m_dis[i]++;
        if (old_ks && raise != 2'b10) begin
          if (!m_fired[i]) begin
            if (m_held[i] == HOLD_TICKS - 1) begin
              m_fired[i] = 1;
              raise = 2'b11;
            end else m_held[i]++;
          end
        end else begin
          m_held[i]  = 0;
          m_fired[i] = 0;
        end
      end
      if (raise != 0) begin
        if (old_pend[i] != 0) drop = 1;
        else m_pend[i] = raise;
      end
    end
    if (drop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
    m_s2   = m_s1;
    m_s1   = key;
    m_pcnt = (m_pcnt + 1) % TICK_DIV;
  endtask

  logic [3:0] log_q[$];
  logic [3:0] exp_q[$];
  logic       smp_valid = 1'b0;
  logic [1:0] smp_key   = '0;
  logic [1:0] smp_code  = '0;
  bit         seen_valid = 0;

  initial begin
    logic [3:0] m_head;
    forever begin
      @(posedge sys_clk);
      if (sys_rst_n && smp_valid && ev_ready) log_q.push_back({smp_key, smp_code});
      model_step();
      #1;
      m_head = (m_q.size() > 0) ? m_q[0] : 4'h0;
      chk("key_state", 32'(key_state), 32'(m_ks));
      chk("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
      chk("ev_key", 32'(ev_key), 32'(m_head[3:2]));
      chk("ev_code", 32'(ev_code), 32'(m_head[1:0]));
      chk("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
      smp_valid = ev_valid;
      smp_key   = ev_key;
      smp_code  = ev_code;
      if (ev_valid) seen_valid = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(tag, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    sys_rst_n = 1'b0; key = '1; ev_ready = 1'b1; clr_overflow = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_state", 32'(key_state), 32'd0);
    chk("rst_ovf", 32'(ev_overflow), 32'd0);
    sys_rst_n = 1'b1;
    cyc(4);
    log_q.delete();

    // clean press / release of key 1
    key[1] = 1'b0; cyc(20);
    chk("press_state", 32'(key_state[1]), 32'd1);
    key[1] = 1'b1; cyc(20);
    exp_q.push_back({2'd1, EV_PRESS});
    exp_q.push_back({2'd1, EV_RELEASE});
    check_log("clean");

    // two-tick glitch on key 0
    seen_valid = 0;
    key[0] = 1'b0; cyc(8);
    key[0] = 1'b1; cyc(20);
    chk("glitch_state", 32'(key_state), 32'd0);
    chk("glitch_valid", 32'(seen_valid), 32'd0);
    check_log("glitch");

    // simultaneous press of keys 3 and 0
    key[3] = 1'b0; key[0] = 1'b0; cyc(20);
    exp_q.push_back({2'd0, EV_PRESS});
    exp_q.push_back({2'd3, EV_PRESS});
    check_log("simul_press");
    key[3] = 1'b1; key[0] = 1'b1; cyc(20);
    exp_q.push_back({2'd0, EV_RELEASE});
    exp_q.push_back({2'd3, EV_RELEASE});
    check_log("simul_release");

    // long press on key 2: one hold, no repeat
    key[2] = 1'b0; cyc(70);
    exp_q.push_back({2'd2, EV_PRESS});
    exp_q.push_back({2'd2, EV_HOLD});
    check_log("hold");
    cyc(40);
    check_log("hold_norepeat");
    key[2] = 1'b1; cyc(20);
    exp_q.push_back({2'd2, EV_RELEASE});
    check_log("hold_release");

    // backpressure: FIFO fills, releases wait, second presses are dropped
    ev_ready = 1'b0;
    key = '0; cyc(20);
    key = '1; cyc(20);
    key = '0; cyc(20);
    chk("ovf_set", 32'(ev_overflow), 32'd1);
    ev_ready = 1'b1; cyc(12);
    for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), EV_PRESS});
    for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), EV_RELEASE});
    check_log("drain");
    clr_overflow = 1'b1; cyc(1);
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(ev_overflow), 32'd0);
    key = '1; cyc(60);
    log_q.delete();

    // reset with two queued events and key 1 held
    ev_ready = 1'b0;
    key[1] = 1'b0; key[2] = 1'b0; cyc(20);
    chk("pre_rst_valid", 32'(ev_valid), 32'd1);
    sys_rst_n = 1'b0; cyc(1);
    chk("mid_rst_valid", 32'(ev_valid), 32'd0);
    chk("mid_rst_key", 32'(ev_key), 32'd0);
    chk("mid_rst_code", 32'(ev_code), 32'd0);
    chk("mid_rst_state", 32'(key_state), 32'd0);
    sys_rst_n = 1'b1; cyc(2);
    chk("post_rst_valid", 32'(ev_valid), 32'd0);
    ev_ready = 1'b1; cyc(20);
    exp_q.push_back({2'd1, EV_PRESS});
    exp_q.push_back({2'd2, EV_PRESS});
    check_log("post_rst");
    key = '1; cyc(30);
    log_q.delete();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 29) == 0) key[k] = ~key[k];
      ev_ready     = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 63) == 0);
      sys_rst_n    = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    sys_rst_n = 1'b1; clr_overflow = 1'b0; ev_ready = 1'b1;
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
